// File: rtl/key_move_ctrl.sv
// Keyboard conditioner between the SoC keycode export and the game block:
// per-frame debounce, WASD auto-repeat moves over valid/ready, Enter start pulse.
module key_move_ctrl #(
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned REPEAT_DELAY    = 15,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Keycode,
  input  logic       FrameSync,
  input  logic       Move_ready,
  output logic       Move_valid,
  output logic [1:0] Move_dir,
  output logic       Start_pulse,
  output logic       Key_active,
  output logic [7:0] Drop_count
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_HELD     = 3'd2,
    ST_REPEAT   = 3'd3,
    ST_LATCHED  = 3'd4
  } state_t;

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_FRAMES - 1);
  localparam logic [7:0] RD_LAST = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0] RP_LAST = 8'(REPEAT_PERIOD - 1);

  function automatic logic is_move(input logic [7:0] k);
    return (k == 8'h1A) || (k == 8'h04) || (k == 8'h16) || (k == 8'h07);
  endfunction

  function automatic logic is_start(input logic [7:0] k);
    return (k == 8'h28);
  endfunction

  function automatic logic [1:0] dir_of(input logic [7:0] k);
    case (k)
      8'h1A:   return 2'b00;
      8'h04:   return 2'b01;
      8'h16:   return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  state_t     state_r, state_nxt_s;
  logic [7:0] key_r, cand_r, cand_nxt_s, cnt_r, cnt_nxt_s, drop_r, drop_nxt_s;
  logic       fs_q_r, ftick_s, emit_s, start_s, xfer_s;
  logic       move_valid_r, valid_nxt_s, start_pulse_r, key_active_r, active_nxt_s;
  logic [1:0] move_dir_r, dir_nxt_s;

  assign ftick_s = FrameSync & ~fs_q_r;
  assign xfer_s  = move_valid_r & Move_ready;

  // Next-state logic: a key change overrides any frame-tick driven transition.
  always_comb begin
    state_nxt_s = state_r;
    cand_nxt_s  = cand_r;
    cnt_nxt_s   = cnt_r;
    emit_s      = 1'b0;
    start_s     = 1'b0;
    if (key_r != cand_r) begin
      cand_nxt_s = key_r;
      cnt_nxt_s  = 8'd0;
      if (is_move(key_r) || is_start(key_r)) begin
        state_nxt_s = ST_DEBOUNCE;
      end else begin
        state_nxt_s = ST_IDLE;
      end
    end else if (ftick_s) begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_DEBOUNCE: begin
          if (cnt_r == DB_LAST) begin
            cnt_nxt_s = 8'd0;
            if (is_move(cand_r)) begin
              emit_s      = 1'b1;
              state_nxt_s = ST_HELD;
            end else if (is_start(cand_r)) begin
              start_s     = 1'b1;
              state_nxt_s = ST_LATCHED;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            cnt_nxt_s = cnt_r + 8'd1;
          end
        end
        ST_HELD: begin
          if (cnt_r == RD_LAST) begin
            emit_s      = 1'b1;
            cnt_nxt_s   = 8'd0;
            state_nxt_s = ST_REPEAT;
          end else begin
            cnt_nxt_s = cnt_r + 8'd1;
          end
        end
        ST_REPEAT: begin
          if (cnt_r == RP_LAST) begin
            emit_s    = 1'b1;
            cnt_nxt_s = 8'd0;
          end else begin
            cnt_nxt_s = cnt_r + 8'd1;
          end
        end
        ST_LATCHED: state_nxt_s = ST_LATCHED;
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 8'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Single-entry move buffer: a move arriving while the slot stays occupied is dropped.
  always_comb begin
    valid_nxt_s = move_valid_r;
    dir_nxt_s   = move_dir_r;
    drop_nxt_s  = drop_r;
    if (emit_s) begin
      if (!move_valid_r || xfer_s) begin
        valid_nxt_s = 1'b1;
        dir_nxt_s   = dir_of(cand_r);
      end else if (drop_r != 8'hFF) begin
        drop_nxt_s = drop_r + 8'd1;
      end else begin
        drop_nxt_s = drop_r;
      end
    end else if (xfer_s) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = move_valid_r;
    end
    active_nxt_s = (state_nxt_s == ST_HELD) || (state_nxt_s == ST_REPEAT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_r       <= ST_IDLE;
      key_r         <= 8'h00;
      cand_r        <= 8'h00;
      cnt_r         <= 8'd0;
      fs_q_r        <= 1'b1;
      move_valid_r  <= 1'b0;
      move_dir_r    <= 2'b00;
      start_pulse_r <= 1'b0;
      key_active_r  <= 1'b0;
      drop_r        <= 8'd0;
    end else begin
      state_r       <= state_nxt_s;
      key_r         <= Keycode;
      cand_r        <= cand_nxt_s;
      cnt_r         <= cnt_nxt_s;
      fs_q_r        <= FrameSync;
      move_valid_r  <= valid_nxt_s;
      move_dir_r    <= dir_nxt_s;
      start_pulse_r <= start_s;
      key_active_r  <= active_nxt_s;
      drop_r        <= drop_nxt_s;
    end
  end

  assign Move_valid  = move_valid_r;
  assign Move_dir    = move_dir_r;
  assign Start_pulse = start_pulse_r;
  assign Key_active  = key_active_r;
  assign Drop_count  = drop_r;

endmodule
